// File: rtl/instruction_fetch_if.sv
// Fetch-side bundle: redirect from the backend, I-cache read port and
// instruction-queue push port. master = fetch unit, slave = its environment.
interface instruction_fetch_if;
  logic        flush;
  logic [31:0] flush_pc;
  logic        imem_read;
  logic [31:0] imem_address;
  logic        imem_resp;
  logic [31:0] imem_rdata;
  logic        iq_full;
  logic        iq_load;
  logic [31:0] iq_pc;
  logic [31:0] iq_next_pc;
  logic [31:0] iq_instr;

  modport master (
    input  flush, flush_pc, imem_resp, imem_rdata, iq_full,
    output imem_read, imem_address, iq_load, iq_pc, iq_next_pc, iq_instr
  );

  modport slave (
    output flush, flush_pc, imem_resp, imem_rdata, iq_full,
    input  imem_read, imem_address, iq_load, iq_pc, iq_next_pc, iq_instr
  );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch: one outstanding I-cache read, push into the instruction queue.
// Optional JAL target prediction when IFETCH_JAL_PREDICT_EN is defined.
//
// state | meaning
// FETCH | read outstanding at pc; a response is pushed or parked
// HOLD  | response parked in hold_* because the queue was full; no read
// DRAIN | flushed while a read was in flight; wait for it, then go to redirect_pc
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
  input  logic                 clk,
  input  logic                 rst,
  instruction_fetch_if.master  bus
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] hold_next_pc_q, hold_next_pc_d;
  logic [31:0] fetch_npc;

`ifdef IFETCH_JAL_PREDICT_EN
  logic        is_jal;
  logic [31:0] jal_imm;

  assign is_jal  = (bus.imem_rdata[6:0] == 7'b1101111);
  assign jal_imm = {{11{bus.imem_rdata[31]}}, bus.imem_rdata[31], bus.imem_rdata[19:12],
                    bus.imem_rdata[20], bus.imem_rdata[30:21], 1'b0};
  assign fetch_npc = is_jal ? (pc_q + jal_imm) : (pc_q + 32'd4);
`else
  assign fetch_npc = pc_q + 32'd4;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= FETCH;
      pc_q           <= RESET_PC;
      redirect_pc_q  <= 32'd0;
      hold_instr_q   <= 32'd0;
      hold_next_pc_q <= 32'd0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      redirect_pc_q  <= redirect_pc_d;
      hold_instr_q   <= hold_instr_d;
      hold_next_pc_q <= hold_next_pc_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    redirect_pc_d    = redirect_pc_q;
    hold_instr_d     = hold_instr_q;
    hold_next_pc_d   = hold_next_pc_q;
    // the address is pc_q in every reading state; pc_q only moves on a response
    // or while in HOLD, so the request stays stable until it completes
    bus.imem_read    = (state_q != HOLD);
    bus.imem_address = pc_q;
    bus.iq_load      = 1'b0;
    bus.iq_pc        = 32'd0;
    bus.iq_next_pc   = 32'd0;
    bus.iq_instr     = 32'd0;

    if (!rst) begin
      case (state_q)
        FETCH: begin
          if (bus.flush) begin
            if (bus.imem_resp) begin
              pc_d = bus.flush_pc;
            end else begin
              redirect_pc_d = bus.flush_pc;
              state_d       = DRAIN;
            end
          end else if (bus.imem_resp) begin
            if (!bus.iq_full) begin
              bus.iq_load    = 1'b1;
              bus.iq_pc      = pc_q;
              bus.iq_next_pc = fetch_npc;
              bus.iq_instr   = bus.imem_rdata;
              pc_d           = fetch_npc;
            end else begin
              hold_instr_d   = bus.imem_rdata;
              hold_next_pc_d = fetch_npc;
              state_d        = HOLD;
            end
          end
        end

        HOLD: begin
          if (bus.flush) begin
            pc_d    = bus.flush_pc;
            state_d = FETCH;
          end else if (!bus.iq_full) begin
            bus.iq_load    = 1'b1;
            bus.iq_pc      = pc_q;
            bus.iq_next_pc = hold_next_pc_q;
            bus.iq_instr   = hold_instr_q;
            pc_d           = hold_next_pc_q;
            state_d        = FETCH;
          end
        end

        DRAIN: begin
          if (bus.imem_resp) begin
            pc_d    = bus.flush ? bus.flush_pc : redirect_pc_q;
            state_d = FETCH;
          end else if (bus.flush) begin
            redirect_pc_d = bus.flush_pc;
          end
        end

        default: state_d = FETCH;
      endcase
    end
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000060, the PC fetched first after reset.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on posedge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port flush  input  1  redirect request from the backend (mispredict or jump resolution).
REQ-005 SHALL have port flush_pc  input  32  redirect target, sampled when flush=1.
REQ-006 SHALL have port imem_read  output  1  I-cache read request.
REQ-007 SHALL have port imem_address  output  32  I-cache read address.
REQ-008 SHALL have port imem_resp  input  1  I-cache read done, one-cycle pulse.
REQ-009 SHALL have port imem_rdata  input  32  fetched instruction, valid when imem_resp=1.
REQ-010 SHALL have port iq_full  input  1  instruction queue full.
REQ-011 SHALL have port iq_load  output  1  push strobe into the instruction queue.
REQ-012 SHALL have ports iq_pc, iq_next_pc and iq_instr  output  32 each  PC, predicted next PC and instruction pushed on iq_load.

Function
REQ-013 SHALL implement states FETCH, HOLD and DRAIN, with registers pc, redirect_pc, hold_instr and hold_next_pc.
REQ-014 FETCH: imem_read=1 and imem_address=pc; DRAIN: imem_read=1 and imem_address=pc (the stale request); HOLD: imem_read=0.
REQ-015 imem_read and imem_address SHALL stay stable from assertion until the imem_resp cycle, flush included.
REQ-016 FETCH with imem_resp=1, iq_full=0, flush=0: iq_load=1 that same cycle (combinational), iq_instr=imem_rdata, iq_pc=pc, iq_next_pc=npc(pc,imem_rdata); pc<=npc; state stays FETCH.
REQ-017 FETCH with imem_resp=1, iq_full=1, flush=0: iq_load=0; hold_instr<=imem_rdata, hold_next_pc<=npc; state->HOLD.
REQ-018 HOLD with iq_full=0, flush=0: iq_load=1, iq_instr=hold_instr, iq_pc=pc, iq_next_pc=hold_next_pc; pc<=hold_next_pc; state->FETCH.
REQ-019 flush=1 SHALL take priority over every push: iq_load=0 that cycle.
REQ-020 flush in FETCH with imem_resp=0: redirect_pc<=flush_pc; state->DRAIN.
REQ-021 flush in FETCH with imem_resp=1, or flush in HOLD: discard the data; pc<=flush_pc; state->FETCH.
REQ-022 DRAIN with imem_resp=1: discard rdata; pc<=(flush ? flush_pc : redirect_pc); state->FETCH.
REQ-023 DRAIN with imem_resp=0 and flush=1: redirect_pc<=flush_pc (latest flush wins).
REQ-024 npc(pc,instr) = pc+4, modulo 2^32 (32'hFFFFFFFC wraps to 0), unless REQ-029 applies.
REQ-025 SHALL have sustained throughput of one push per imem_resp; no bubble cycle is inserted by fetch when imem_resp arrives every cycle.
REQ-026 iq_load SHALL never assert when iq_full=1, in DRAIN, or on a cycle with flush=1.

Reset
REQ-027 On rst=1, regardless of clk: state=FETCH, pc=RESET_PC, redirect_pc=0, hold_instr=0, hold_next_pc=0.
REQ-028 During reset, outputs SHALL be imem_read=1 (address RESET_PC after release), iq_load=0 and iq_* data=0. Reset mid-request abandons it without a drain; the cache is reset by the same rst.

Configuration
REQ-029 Macro IFETCH_JAL_PREDICT_EN: when defined, if instr[6:0]=7'b1101111, npc = pc + sign-extended J-immediate {instr[31],instr[19:12],instr[20],instr[30:21],1'b0}, mod 2^32; when undefined, npc is always pc+4 and the immediate logic is absent.

Verification
REQ-030 Release reset; imem_resp=1 every cycle with rdata 0x00000013 and iq_full=0 -> imem_address 0x60,0x64,0x68; iq_load=1 each resp cycle; iq_next_pc=iq_pc+4.
REQ-031 Set iq_full=1 on the resp for pc 0x64 and hold it 3 cycles -> HOLD, imem_read=0, no iq_load; on iq_full=0, one push (pc 0x64, next 0x68), then fetch resumes at 0x68.
REQ-032 flush=1 with flush_pc=0x200 while the 0x68 request is outstanding; resp arrives 2 cycles later -> address stays 0x68 until resp, the rdata is not pushed, next request is 0x200.
REQ-033 Two flushes in DRAIN (0x200, then 0x300), then resp -> next fetch 0x300; flush coincident with resp in FETCH -> no push, next fetch is flush_pc.
REQ-034 With IFETCH_JAL_PREDICT_EN, pc 0x100 fetches 0xFF9FF0EF (jal ra,-8) -> iq_next_pc=0xF8 and next fetch 0xF8; without the macro -> 0x104.
REQ-035 Assert rst in HOLD and in DRAIN -> state FETCH and pc=0x60 immediately, iq_load=0, no stale push after release.
